// File: rtl/result_writeback_pkg.sv
// Shared types for the result write-back block: FSM state encoding and
// a small helper used to size the word index.
package result_writeback_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Width of an index over n items, never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/result_writeback.sv
// Result write-back: captures a packed block of DEPTH result words and
// writes them one per accepted memory request at consecutive addresses.
//
// Optional feature macro: RESULT_WRITEBACK_PTR_AUTO_EN
//   undefined : pointer reloads base_addr on every capture
//   defined   : pointer loads base_addr only on the first capture after
//               reset; later blocks continue after the last written word
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a block, in_ready=1
// ST_WRITE | issuing writes, word[index] at the write pointer
// ST_DONE  | single-cycle done pulse, then back to idle
module result_writeback
   import result_writeback_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [2*WIDTH*DEPTH-1:0]  in_data,
   output logic                      in_ready,
   input  logic [ADDR_W-1:0]         base_addr,
   output logic                      mem_wr_en,
   output logic [ADDR_W-1:0]         mem_wr_addr,
   output logic [2*WIDTH-1:0]        mem_wr_data,
   input  logic                      mem_wr_ready,
   output logic                      busy,
   output logic                      done
);

   localparam int WW    = 2 * WIDTH;
   localparam int IDX_W = idx_width(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_e             state_q, state_d;
   logic [WW-1:0]      buf_q [DEPTH];
   logic [WW-1:0]      buf_d [DEPTH];
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d;
`ifdef RESULT_WRITEBACK_PTR_AUTO_EN
   logic               first_q, first_d;
`endif

   // Outputs decode straight from registered state so they stay stable
   // for as long as the memory withholds mem_wr_ready.
   always_comb begin
      in_ready    = (state_q == ST_IDLE);
      busy        = (state_q != ST_IDLE);
      mem_wr_en   = (state_q == ST_WRITE);
      done        = (state_q == ST_DONE);
      mem_wr_addr = ptr_q;
      mem_wr_data = buf_q[idx_q];
   end

   // Next-state, buffer capture, index and pointer advance.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
`ifdef RESULT_WRITEBACK_PTR_AUTO_EN
      first_d = first_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               for (int k = 0; k < DEPTH; k++) begin
                  buf_d[k] = in_data[WW*k +: WW];
               end
               idx_d = '0;
`ifdef RESULT_WRITEBACK_PTR_AUTO_EN
               // Pointer already sits one past the previous block's last word.
               if (first_q) begin
                  ptr_d = base_addr;
               end
               first_d = 1'b0;
`else
               ptr_d = base_addr;
`endif
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (mem_wr_ready) begin
               idx_d = idx_q + IDX_W'(1);
               ptr_d = ptr_q + ADDR_W'(1);
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything, aborting any block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            buf_q[k] <= '0;
         end
`ifdef RESULT_WRITEBACK_PTR_AUTO_EN
         first_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         for (int k = 0; k < DEPTH; k++) begin
            buf_q[k] <= buf_d[k];
         end
`ifdef RESULT_WRITEBACK_PTR_AUTO_EN
         first_q <= first_d;
`endif
      end
   end

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback (WIDTH=8, DEPTH=4, ADDR_W=8).
// Expected writes come from a block-level model: word k of a block lands
// at start+k, where start is base_addr or the continuing pointer.
module tb_result_writeback;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 8;
`ifdef RESULT_WRITEBACK_PTR_AUTO_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      in_valid;
   logic [2*WIDTH*DEPTH-1:0]  in_data;
   logic                      in_ready;
   logic [ADDR_W-1:0]         base_addr;
   logic                      mem_wr_en;
   logic [ADDR_W-1:0]         mem_wr_addr;
   logic [2*WIDTH-1:0]        mem_wr_data;
   logic                      mem_wr_ready;
   logic                      busy;
   logic                      done;

   int total = 0;
   int bad   = 0;

   logic [7:0] model_ptr   = 8'h00;
   bit         model_first = 1'b1;

   result_writeback #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .base_addr    (base_addr),
      .mem_wr_en    (mem_wr_en),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_ready (mem_wr_ready),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_busy"},     32'(busy),     32'd0);
      chk({tag, "_done"},     32'(done),     32'd0);
      chk({tag, "_wr_en"},    32'(mem_wr_en), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_ptr   = 8'h00;
      model_first = 1'b1;
   endtask

   // One block: handshake in the current IDLE cycle, then cycle-by-cycle
   // checking of every write request until the done pulse. Ends at the
   // negedge of the done cycle (or after an abort by reset).
   task automatic run_block(input logic [63:0] data, input logic [7:0] base,
                            input int stall_word, input int stall_cycles,
                            input bit rand_stall, input bit keep_valid,
                            input int abort_at);
      logic [7:0] start;
      int w, lat, stalls, stall_left;
      bit finished;
      @(negedge clk);
      chk("hs_in_ready", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      in_data   = data;
      base_addr = base;
      start = (AUTO && !model_first) ? model_ptr : base;
      model_first = 1'b0;
      @(negedge clk);
      if (!keep_valid) in_valid = 1'b0;
      w = 0; lat = 1; stalls = 0; finished = 1'b0;
      stall_left = (stall_word == 0) ? stall_cycles : 0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         if (w < DEPTH) begin
            chk("wr_en",   32'(mem_wr_en),   32'd1);
            chk("wr_addr", 32'(mem_wr_addr), 32'(8'(start + w)));
            chk("wr_data", 32'(mem_wr_data), 32'(data[16*w +: 16]));
            chk("wr_busy", 32'(busy),        32'd1);
            chk("wr_done", 32'(done),        32'd0);
            chk("wr_rdy",  32'(in_ready),    32'd0);
            in_data   = {$urandom, $urandom};
            base_addr = 8'($urandom);
            if (abort_at == w) begin
               rst = 1'b1;
               mem_wr_ready = 1'b1;
               in_valid = 1'b0;
               @(negedge clk);
               rst = 1'b0;
               check_idle("abort");
               chk("abort_addr", 32'(mem_wr_addr), 32'd0);
               chk("abort_data", 32'(mem_wr_data), 32'd0);
               model_ptr   = 8'h00;
               model_first = 1'b1;
               repeat (3) begin
                  @(negedge clk);
                  check_idle("post_abort");
               end
               return;
            end
            if (stall_left > 0) begin
               mem_wr_ready = 1'b0;
               stall_left--;
               stalls++;
            end else if (rand_stall && $urandom_range(0, 2) == 0) begin
               mem_wr_ready = 1'b0;
               stalls++;
            end else begin
               mem_wr_ready = 1'b1;
               w++;
               if (w == stall_word) stall_left = stall_cycles;
            end
         end else begin
            chk("done_pulse", 32'(done),      32'd1);
            chk("done_wr_en", 32'(mem_wr_en), 32'd0);
            chk("done_busy",  32'(busy),      32'd1);
            chk("done_rdy",   32'(in_ready),  32'd0);
            chk("latency",    32'(lat),       32'(DEPTH + 1 + stalls));
            model_ptr = 8'(start + DEPTH);
            finished = 1'b1;
         end
         if (!finished) begin
            @(negedge clk);
            lat++;
         end
      end
      if (!finished) chk("block_timeout", 32'd0, 32'd1);
      mem_wr_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      base_addr = '0;
      mem_wr_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_wr_en", 32'(mem_wr_en),   32'd0);
      chk("rst_addr",  32'(mem_wr_addr), 32'd0);
      chk("rst_data",  32'(mem_wr_data), 32'd0);
      chk("rst_busy",  32'(busy),        32'd0);
      chk("rst_done",  32'(done),        32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_idle("after_rst");

      // Basic block, no backpressure.
      run_block(64'h0004_0003_0002_0001, 8'h10, -1, 0, 1'b0, 1'b0, -1);
      @(negedge clk);
      check_idle("after_basic");

      // Three stall cycles on word 2.
      run_block(64'h0004_0003_0002_0001, 8'h10, 2, 3, 1'b0, 1'b0, -1);

      // Address wrap.
      do_reset();
      run_block(64'hDDDD_CCCC_BBBB_AAAA, 8'hFE, -1, 0, 1'b0, 1'b0, -1);

      // Reset after two accepted writes, then a fresh block.
      run_block(64'h1111_2222_3333_4444, 8'h40, -1, 0, 1'b0, 1'b0, 2);
      run_block(64'h5555_6666_7777_8888, 8'h30, -1, 0, 1'b0, 1'b0, -1);

      // Back-to-back blocks at base 0x20 starting from reset.
      do_reset();
      run_block(64'hA003_A002_A001_A000, 8'h20, -1, 0, 1'b0, 1'b0, -1);
      run_block(64'hB003_B002_B001_B000, 8'h20, -1, 0, 1'b0, 1'b0, -1);

      // in_valid held with toggling data during WRITE; next block taken
      // in the IDLE cycle right after done.
      run_block(64'hC0DE_BEEF_1234_5678, 8'h60, -1, 0, 1'b0, 1'b1, -1);
      run_block(64'h0F0F_F0F0_AA55_55AA, 8'h70, -1, 0, 1'b0, 1'b0, -1);

      // Randomised blocks with random backpressure and gaps.
      for (int b = 0; b < 25; b++) begin
         int gap;
         run_block({$urandom, $urandom}, 8'($urandom), -1, 0, 1'b1, 1'b0, -1);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check_idle("gap");
         end
      end
      @(negedge clk);
      check_idle("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand width; each result word is 2*WIDTH bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of result words per block.
REQ-003 The block SHALL have parameter ADDR_W, default 8, the memory address width.
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid  input  1  an upstream result block is present.
REQ-007 The block SHALL have port in_data  input  2*WIDTH*DEPTH  packed result block; word k occupies bits [2*WIDTH*(k+1)-1 : 2*WIDTH*k].
REQ-008 The block SHALL have port in_ready  output  1  the block can accept a result block.
REQ-009 The block SHALL have port base_addr  input  ADDR_W  memory address of word 0.
REQ-010 The block SHALL have port mem_wr_en  output  1  a memory write request.
REQ-011 The block SHALL have port mem_wr_addr  output  ADDR_W  the write address.
REQ-012 The block SHALL have port mem_wr_data  output  2*WIDTH  the write data.
REQ-013 The block SHALL have port mem_wr_ready  input  1  memory accepts the request this cycle.
REQ-014 The block SHALL have port busy  output  1  a block is being written.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-016 The FSM SHALL have three states: IDLE, WRITE and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in WRITE and DONE, in_ready SHALL be 0.
REQ-018 A handshake (in_valid && in_ready) SHALL capture in_data into an internal buffer, clear the word index to 0 and load the write pointer, then move to WRITE on the next cycle.
REQ-019 In WRITE, mem_wr_en SHALL be 1, mem_wr_data SHALL be buffer word[index], and mem_wr_addr SHALL be the write pointer.
REQ-020 A write SHALL count as accepted only when mem_wr_en && mem_wr_ready; on acceptance, index and pointer SHALL each increment by 1.
REQ-021 While mem_wr_ready is 0, addr, data and mem_wr_en SHALL be held stable.
REQ-022 The pointer SHALL wrap modulo 2^ADDR_W (for example 8'hFF+1 = 8'h00); the wrap is not an error.
REQ-023 On acceptance of word DEPTH-1, the FSM SHALL go WRITE->DONE.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 With no backpressure, the latency from handshake to done SHALL be DEPTH+1 cycles; the minimum block-to-block spacing SHALL be DEPTH+2 cycles.
REQ-027 in_valid asserted outside IDLE SHALL be ignored, with no capture; upstream holds it.
REQ-028 Changes to in_data or base_addr after capture SHALL NOT affect the current block.

Reset
REQ-029 When rst=1 at a clock edge, the FSM SHALL go to IDLE, index and pointer SHALL go to 0, and mem_wr_en, done and busy SHALL go to 0; in_ready SHALL be 1 in the cycle after rst deasserts.
REQ-030 Reset during WRITE SHALL abort the block immediately, with no further writes and no done.
REQ-031 mem_wr_addr and mem_wr_data SHALL reset to 0.

Configuration
REQ-032 Macro RESULT_WRITEBACK_PTR_AUTO_EN SHALL select how the write pointer is loaded.
REQ-033 Without the macro, the pointer SHALL load base_addr on every capture.
REQ-034 With the macro, the pointer SHALL load base_addr only on the first capture after reset; later blocks SHALL continue from the last written address+1, with wrap per REQ-022.

Structure
REQ-035 Package result_writeback_pkg SHALL hold the state enum (2-bit logic: IDLE, WRITE, DONE).
REQ-036 No sub-module SHALL be used; the buffer, FSM and counters SHALL live in result_writeback.

Verification (WIDTH=8, DEPTH=4, ADDR_W=8)
REQ-037 in_data={16'h0004,16'h0003,16'h0002,16'h0001}, base_addr=8'h10, mem_wr_ready=1 -> writes (10,0001),(11,0002),(12,0003),(13,0004) on consecutive cycles, done pulses 1 cycle after the last write, in_ready returns to 1.
REQ-038 Same block with mem_wr_ready low for 3 cycles on word 2 -> addr 12 / data 0003 held for 4 cycles, four writes total, done delayed by 3 cycles.
REQ-039 base_addr=8'hFE -> addresses FE, FF, 00, 01.
REQ-040 rst pulsed after 2 accepted writes -> no further mem_wr_en, no done, busy=0 next cycle; a new block then writes from its own base_addr.
REQ-041 Two back-to-back blocks with base 8'h20: without the macro, both write 20..23; with RESULT_WRITEBACK_PTR_AUTO_EN, the second writes 24..27.
REQ-042 in_valid held high with in_data toggled during WRITE -> no capture and the first block's data is unaltered; the second block is captured in the IDLE cycle following done.
